// File: rtl/countdown_timer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : timer_pkg
// Brief    : Shared types and BCD helpers for the MM:SS countdown controller.
// Revision : 1.0 - initial release
// ============================================================================
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [3:0] C_DIGIT_MAX = 4'd9;
   localparam logic [3:0] C_TENS_MAX  = 4'd5;

   typedef struct packed {
      logic [7:0] mm;
      logic [7:0] ss;
      logic       zero;
   } mmss_dec_t;

   function automatic logic bcd_valid(input logic [7:0] v);
      return (v[7:4] <= C_TENS_MAX) && (v[3:0] <= C_DIGIT_MAX);
   endfunction

   // One 00..59 field minus one; 00 rolls to 59 so the caller can borrow.
   function automatic logic [7:0] bcd_dec_field(input logic [7:0] v);
      if (v[3:0] != 4'd0)
         return {v[7:4], v[3:0] - 4'd1};
      else if (v[7:4] != 4'd0)
         return {v[7:4] - 4'd1, C_DIGIT_MAX};
      else
         return {C_TENS_MAX, C_DIGIT_MAX};
   endfunction

   function automatic mmss_dec_t bcd_dec_mmss(input logic [7:0] mm, input logic [7:0] ss);
      mmss_dec_t r;
      r.mm = mm;
      r.ss = ss;
      // 00:00 saturates instead of wrapping.
      if ((mm != 8'h00) || (ss != 8'h00)) begin
         r.ss = bcd_dec_field(ss);
         if (ss == 8'h00)
            r.mm = bcd_dec_field(mm);
      end
      r.zero = (r.mm == 8'h00) && (r.ss == 8'h00);
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/countdown_timer_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : countdown_timer_ctrl_if
// Brief    : Button pulses, preset and display-side outputs of the timer.
// Revision : 1.0 - initial release
// ============================================================================
interface countdown_timer_ctrl_if;
   logic       start;
   logic       pause;
   logic       clear;
   logic [7:0] preset_min;
   logic [7:0] preset_sec;
   logic [7:0] min_bcd;
   logic [7:0] sec_bcd;
   logic       running;
   logic       done;
   logic       tick;

   modport master (
      output start, pause, clear, preset_min, preset_sec,
      input  min_bcd, sec_bcd, running, done, tick
   );

   modport slave (
      input  start, pause, clear, preset_min, preset_sec,
      output min_bcd, sec_bcd, running, done, tick
   );
endinterface
`default_nettype wire

// File: rtl/countdown_timer_ctrl_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : tick_prescaler
// Brief    : Counts 0..TICK_CYCLES-1 while enabled; wrap flags the last count.
// Revision : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
   parameter int TICK_CYCLES = 100_000_000
) (
   input  wire logic sysclk,
   input  wire logic rst_n,
   input  wire logic en,
   input  wire logic clr,
   output logic      wrap
);
   localparam int             C_CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(TICK_CYCLES - 1);

   logic [C_CNT_W-1:0] r_count;

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n)
         r_count <= '0;
      else if (clr)
         r_count <= '0;
      else if (en)
         r_count <= (r_count == C_LAST) ? '0 : r_count + C_CNT_W'(1);
   end

   assign wrap = en && (r_count == C_LAST);
endmodule
`default_nettype wire

// File: rtl/countdown_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : countdown_timer_ctrl
// Brief    : MM:SS BCD countdown FSM driving a one-second prescaler.
// Revision : 1.0 - initial release
// ============================================================================
module countdown_timer_ctrl
   import timer_pkg::*;
#(
   parameter int TICK_CYCLES = 100_000_000
) (
   input  wire logic sysclk,
   input  wire logic rst_n,
   countdown_timer_ctrl_if.slave bus
);
   state_t     r_state, w_state_nxt;
   logic [7:0] r_min, w_min_nxt;
   logic [7:0] r_sec, w_sec_nxt;
   logic       r_tick, w_tick_nxt;
   logic       w_wrap;
   logic       w_pre_en;
   logic       w_pre_clr;
   logic       w_preset_ok;
   logic       w_preset_zero;
   mmss_dec_t  w_dec;

   assign w_pre_en      = (r_state == RUN);
   assign w_pre_clr     = (r_state == IDLE) || bus.clear;
   assign w_preset_ok   = bcd_valid(bus.preset_min) && bcd_valid(bus.preset_sec);
   assign w_preset_zero = (bus.preset_min == 8'h00) && (bus.preset_sec == 8'h00);
   assign w_dec         = bcd_dec_mmss(r_min, r_sec);

   tick_prescaler #(
      .TICK_CYCLES (TICK_CYCLES)
   ) u_prescaler (
      .sysclk (sysclk),
      .rst_n  (rst_n),
      .en     (w_pre_en),
      .clr    (w_pre_clr),
      .wrap   (w_wrap)
   );

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_min   <= 8'h00;
         r_sec   <= 8'h00;
         r_tick  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_min   <= w_min_nxt;
         r_sec   <= w_sec_nxt;
         r_tick  <= w_tick_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_min_nxt   = r_min;
      w_sec_nxt   = r_sec;
      w_tick_nxt  = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_min_nxt = bus.preset_min;
            w_sec_nxt = bus.preset_sec;
            if (!bus.clear && !bus.pause && bus.start && w_preset_ok)
               w_state_nxt = w_preset_zero ? DONE : RUN;
         end
         RUN: begin
            if (bus.clear) begin
               w_state_nxt = IDLE;
            end else begin
               if (bus.pause)
                  w_state_nxt = PAUSED;
               // A wrap on the pause cycle still takes its second first.
               if (w_wrap) begin
                  w_min_nxt  = w_dec.mm;
                  w_sec_nxt  = w_dec.ss;
                  w_tick_nxt = 1'b1;
                  if (w_dec.zero)
                     w_state_nxt = DONE;
               end
            end
         end
         PAUSED: begin
            if (bus.clear)
               w_state_nxt = IDLE;
            else if (!bus.pause && bus.start)
               w_state_nxt = RUN;
         end
         DONE: begin
            w_min_nxt = 8'h00;
            w_sec_nxt = 8'h00;
            if (bus.clear)
               w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign bus.min_bcd = r_min;
   assign bus.sec_bcd = r_sec;
   assign bus.tick    = r_tick;
   assign bus.running = (r_state == RUN);
   assign bus.done    = (r_state == DONE);
endmodule
`default_nettype wire
